sha_2_message_expansion: RTL
============================

Name: sha_2_message_expansion

Overview:
- Producer side of the SHA-256 compression datapath: accepts one 512-bit message block as 16 sequential 32-bit words and emits the full 64-word message schedule W0..W63, one word per handshake.
- Sits between the message padder/input buffer and the SHA-256 compression round engine.
- Uses the shared sha_2_pkg ssig0/ssig1 functions.

Parameters:
- data_width, 32, word width; only 32 is supported (SHA-256).

Ports:
- clk  input  1  single system clock; all state on rising edge.
- nrst  input  1  asynchronous, active-low reset.
- data_in  input  32  message word Mt, t=0..15, big-endian word order within the block.
- data_in_valid  input  1  data_in valid.
- data_in_last  input  1  block is the final block of the message; sampled only on the t=15 handshake.
- data_in_ready  output  1  block accepts data_in this cycle.
- data_out  output  32  schedule word Wt.
- data_out_id  output  6  index t of data_out, 0..63.
- data_out_last  output  1  asserted with W63 of a block whose data_in_last was set.
- data_out_valid  output  1  data_out, data_out_id and data_out_last are valid.
- data_out_ready  input  1  downstream accepts data_out.

Behaviour:
- Reset, asynchronous: data_out=0, data_out_id=0, data_out_last=0, data_out_valid=0, state=LOAD, word counter t=0, 16-word window cleared, last flag cleared. data_in_ready is combinational and equals 1 out of reset.
- Output slot free (slot_free) = !data_out_valid || data_out_ready. An output word transfers when data_out_valid && data_out_ready.
- LOAD state (t=0..15):
  - data_in_ready = slot_free.
  - On an input handshake: data_in is shifted into the window newest position and loaded into data_out. data_out_id=t and data_out_valid=1 next cycle (latency is 1 cycle). t increments.
  - On the t=15 handshake, data_in_last is captured into the last flag and the state moves to EXPAND.
- EXPAND state (t=16..63):
  - data_in_ready=0.
  - Each cycle slot_free=1: Wt = ssig1(W[t-2]) + W[t-7] + ssig0(W[t-15]) + W[t-16], computed from the window. Addition wraps mod 2^32; carries are discarded.
  - Wt is shifted into the window, loaded into data_out with data_out_id=t, and t increments.
  - Sustained rate is 1 word/cycle when data_out_ready is held high.
- Completion: when W63 is loaded, data_out_last = last flag. t wraps to 0, state returns to LOAD and the last flag clears. Accepting the next block's M0 may overlap the W63 handshake, since the slot is free in that cycle.
- Backpressure: while data_out_valid=1 and data_out_ready=0, data_out, data_out_id, data_out_last, the window and t are all held stable, and no input is accepted.
- data_out_last=0 on every word other than W63.
- data_in_last asserted on words t=0..14 is ignored.
- Reset asserted mid-block discards the partial block. After release, the next accepted word is treated as M0.
- A data_in_valid drop mid-LOAD simply pauses the block; there is no timeout.

Optional Feature:
- Macro: SHA_2_MSG_EXP_PROTOCOL_CHECK_EN.
- Defined:
  - Adds output port protocol_error (1 bit, reset 0).
  - protocol_error is set sticky when a handshake occurs with data_in_last=1 at t!=15.
  - It clears only on nrst.
  - Datapath behaviour is unchanged.
- Undefined: the port and its logic are absent.

Test Plan:
- "abc" block: M0=0x61626380, M1..M14=0, M15=0x00000018, data_in_last=1, data_out_ready held 1 -> 64 outputs, ids 0..63 in order. W0=0x61626380, W15=0x00000018, W16=0x61626380, W17=0x000F0000. W16..W63 match the sha_2_pkg reference model, and data_out_last=1 only on id 63.
- Backpressure: deassert data_out_ready for 5 cycles when data_out_id=20 -> data_out/id stable for all 5 cycles. W21 appears the cycle after ready returns, with no word lost or duplicated.
- Input gaps: data_in_valid toggles 1/0 during LOAD -> ids still 0..15 contiguous. data_in_ready=0 throughout EXPAND even with data_in_valid=1.
- Back-to-back blocks: block A with last=0, then block B (same "abc" words) with last=1 -> A's W63 has data_out_last=0 and B's W63 has data_out_last=1. B's W16=0x61626380, proving the window reloads.
- Reset mid-operation: pulse nrst low at data_out_id=30 -> immediately data_out_valid=0 and data_out_id=0. After release, data_in_ready=1, and a fresh "abc" block yields W17=0x000F0000.
- With SHA_2_MSG_EXP_PROTOCOL_CHECK_EN: data_in_last=1 on M7 -> protocol_error=1 the next cycle and stays set, and all W outputs are unaffected. Without the macro, the same stimulus produces correct W outputs.

Source files
------------

// File: rtl/sha_2_message_expansion_if.sv
// Stream interface for the SHA-256 message schedule expander: message words in, schedule words out.
// protocol_error exists only when SHA_2_MSG_EXP_PROTOCOL_CHECK_EN is defined.
interface sha_2_message_expansion_if #(
    parameter int data_width = 32
);
    logic [data_width-1:0] data_in;
    logic                  data_in_valid;
    logic                  data_in_last;
    logic                  data_in_ready;
    logic [data_width-1:0] data_out;
    logic [5:0]            data_out_id;
    logic                  data_out_last;
    logic                  data_out_valid;
    logic                  data_out_ready;
`ifdef SHA_2_MSG_EXP_PROTOCOL_CHECK_EN
    logic                  protocol_error;
`endif

    modport master (
        output data_in, data_in_valid, data_in_last, data_out_ready,
        input  data_in_ready, data_out, data_out_id, data_out_last, data_out_valid
`ifdef SHA_2_MSG_EXP_PROTOCOL_CHECK_EN
        , input protocol_error
`endif
    );

    modport slave (
        input  data_in, data_in_valid, data_in_last, data_out_ready,
        output data_in_ready, data_out, data_out_id, data_out_last, data_out_valid
`ifdef SHA_2_MSG_EXP_PROTOCOL_CHECK_EN
        , output protocol_error
`endif
    );
endinterface

// File: rtl/sha_2_message_expansion.sv
// SHA-256 message schedule: loads M0..M15, then expands W16..W63 from a sliding 16-word window.
// Optional macro SHA_2_MSG_EXP_PROTOCOL_CHECK_EN adds a sticky protocol_error output.
module sha_2_message_expansion #(
    parameter int data_width = 32
) (
    input logic                 clk,
    input logic                 nrst,
    sha_2_message_expansion_if.slave bus
);
    typedef enum logic {LOAD, EXPAND} state_t;

    state_t                     state;
    logic [5:0]                 t;
    logic [15:0][data_width-1:0] win;
    logic                       last_flag;

    logic                       slot_free;
    logic                       in_fire;
    logic                       exp_fire;
    logic                       step;
    logic [data_width-1:0]      exp_word;
    logic [data_width-1:0]      next_word;

    function automatic logic [data_width-1:0] rotr(input logic [data_width-1:0] x,
                                                   input int unsigned n);
        return (x >> n) | (x << (data_width - n));
    endfunction

    function automatic logic [data_width-1:0] ssig0(input logic [data_width-1:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [data_width-1:0] ssig1(input logic [data_width-1:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // win[k] holds W[t-16+k]; win[15] is the most recent word
    assign slot_free          = !bus.data_out_valid || bus.data_out_ready;
    assign bus.data_in_ready  = (state == LOAD) && slot_free;
    assign in_fire            = bus.data_in_valid && bus.data_in_ready;
    assign exp_fire           = (state == EXPAND) && slot_free;
    assign step               = in_fire || exp_fire;
    assign exp_word           = ssig1(win[14]) + win[9] + ssig0(win[1]) + win[0];
    assign next_word          = (state == LOAD) ? bus.data_in : exp_word;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state              <= LOAD;
            t                  <= 6'd0;
            win                <= '0;
            last_flag          <= 1'b0;
            bus.data_out       <= '0;
            bus.data_out_id    <= 6'd0;
            bus.data_out_last  <= 1'b0;
            bus.data_out_valid <= 1'b0;
        end else if (step) begin
            win                <= {next_word, win[15:1]};
            bus.data_out       <= next_word;
            bus.data_out_id    <= t;
            bus.data_out_valid <= 1'b1;
            bus.data_out_last  <= (state == EXPAND) && (t == 6'd63) && last_flag;
            t                  <= t + 6'd1;
            if (state == LOAD && t == 6'd15) begin
                last_flag <= bus.data_in_last;
                state     <= EXPAND;
            end
            if (state == EXPAND && t == 6'd63) begin
                last_flag <= 1'b0;
                state     <= LOAD;
            end
        end else if (bus.data_out_ready) begin
            bus.data_out_valid <= 1'b0;
        end
    end

`ifdef SHA_2_MSG_EXP_PROTOCOL_CHECK_EN
    // A last marker is only meaningful on M15; anything earlier is flagged until reset
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            bus.protocol_error <= 1'b0;
        end else if (in_fire && bus.data_in_last && (t != 6'd15)) begin
            bus.protocol_error <= 1'b1;
        end
    end
`endif

endmodule
